// File: rtl/morse_pkg.sv
// -----------------------------------------------------------------------------
// morse_pkg
// Shared types and constants for the Morse keyer: FSM state encoding, element
// and gap durations in units, ASCII landmarks, the lookup-result struct and a
// helper that derives a character's total duration from its pattern.
// -----------------------------------------------------------------------------
package morse_pkg;

    typedef enum logic [2:0] {
        IDLE,
        MARK,
        GAP,
        TAIL,
        BAD
    } state_t;

    // Durations in Morse units
    localparam int DOT_UNITS  = 1;
    localparam int DASH_UNITS = 3;
    localparam int EGAP_UNITS = 1;   // gap between elements of one character
    localparam int CGAP_UNITS = 3;   // trailer after the last element
    localparam int WGAP_UNITS = 4;   // space character; adds to trailer for 7

    // ASCII landmarks
    localparam logic [6:0] ASCII_SPACE   = 7'h20;
    localparam logic [6:0] ASCII_UPPER_A = 7'h41;
    localparam logic [6:0] ASCII_LOWER_A = 7'h61;
    localparam logic [6:0] ASCII_LOWER_Z = 7'h7A;
    localparam logic [6:0] ASCII_ZERO    = 7'h30;
    localparam logic [6:0] CASE_OFFSET   = 7'h20;

    // Lookup result. pat[i] is element i (i=0 sent first): 1=dash, 0=dot.
    // len==0 with valid=1 denotes the space character.
    typedef struct packed {
        logic       valid;
        logic [2:0] len;
        logic [4:0] pat;
        logic [4:0] units;
    } morse_code_t;

    // Total units of a character: marks + inter-element gaps + trailer.
    // A zero-length pattern is the word space.
    function automatic logic [4:0] char_units_calc(input logic [2:0] len,
                                                   input logic [4:0] pat);
        int total;
        total = 0;
        if (len == 3'd0) begin
            total = WGAP_UNITS;
        end else begin
            for (int i = 0; i < 5; i++) begin
                if (i < int'(len)) begin
                    total += pat[i] ? DASH_UNITS : DOT_UNITS;
                end
            end
            total += (int'(len) - 1) * EGAP_UNITS + CGAP_UNITS;
        end
        return 5'(total);
    endfunction

endpackage

// File: rtl/morse_keyer_if.sv
// -----------------------------------------------------------------------------
// morse_keyer_if
// Character handshake between the character source and the keyer.
//   char_in    : ASCII code, sampled on accept
//   char_valid : source has a character
//   char_ready : keyer can take a character this cycle
// Accept = char_valid & char_ready at a rising clock edge.
// -----------------------------------------------------------------------------
interface morse_keyer_if;

    logic [6:0] char_in;
    logic       char_valid;
    logic       char_ready;

    modport master (
        output char_in,
        output char_valid,
        input  char_ready
    );

    modport slave (
        input  char_in,
        input  char_valid,
        output char_ready
    );

endinterface

// File: rtl/morse_rom.sv
// -----------------------------------------------------------------------------
// morse_rom
// Combinational ASCII -> Morse lookup.
//   ascii : 7-bit ASCII code
//   code  : {valid, len, pat, units}; units is 0 for unsupported characters
// Supports A-Z, 0-9 and space; lowercase folds to uppercase when FOLD_CASE=1.
// Pattern literals read right-to-left in send order (bit 0 is sent first).
// -----------------------------------------------------------------------------
module morse_rom
    import morse_pkg::*;
#(
    parameter bit FOLD_CASE = 1'b1
) (
    input  logic [6:0]  ascii,
    output morse_code_t code
);

    logic [6:0] folded;
    logic       valid;
    logic [2:0] len;
    logic [4:0] pat;

    always_comb begin
        folded = ascii;
        if (FOLD_CASE && (ascii >= ASCII_LOWER_A) && (ascii <= ASCII_LOWER_Z)) begin
            folded = ascii - CASE_OFFSET;
        end

        valid = 1'b1;
        len   = 3'd0;
        pat   = 5'b00000;
        case (folded)
            ASCII_SPACE: begin len = 3'd0; pat = 5'b00000; end
            7'h41: begin len = 3'd2; pat = 5'b00010; end  // A .-
            7'h42: begin len = 3'd4; pat = 5'b00001; end  // B -...
            7'h43: begin len = 3'd4; pat = 5'b00101; end  // C -.-.
            7'h44: begin len = 3'd3; pat = 5'b00001; end  // D -..
            7'h45: begin len = 3'd1; pat = 5'b00000; end  // E .
            7'h46: begin len = 3'd4; pat = 5'b00100; end  // F ..-.
            7'h47: begin len = 3'd3; pat = 5'b00011; end  // G --.
            7'h48: begin len = 3'd4; pat = 5'b00000; end  // H ....
            7'h49: begin len = 3'd2; pat = 5'b00000; end  // I ..
            7'h4A: begin len = 3'd4; pat = 5'b01110; end  // J .---
            7'h4B: begin len = 3'd3; pat = 5'b00101; end  // K -.-
            7'h4C: begin len = 3'd4; pat = 5'b00010; end  // L .-..
            7'h4D: begin len = 3'd2; pat = 5'b00011; end  // M --
            7'h4E: begin len = 3'd2; pat = 5'b00001; end  // N -.
            7'h4F: begin len = 3'd3; pat = 5'b00111; end  // O ---
            7'h50: begin len = 3'd4; pat = 5'b00110; end  // P .--.
            7'h51: begin len = 3'd4; pat = 5'b01011; end  // Q --.-
            7'h52: begin len = 3'd3; pat = 5'b00010; end  // R .-.
            7'h53: begin len = 3'd3; pat = 5'b00000; end  // S ...
            7'h54: begin len = 3'd1; pat = 5'b00001; end  // T -
            7'h55: begin len = 3'd3; pat = 5'b00100; end  // U ..-
            7'h56: begin len = 3'd4; pat = 5'b01000; end  // V ...-
            7'h57: begin len = 3'd3; pat = 5'b00110; end  // W .--
            7'h58: begin len = 3'd4; pat = 5'b01001; end  // X -..-
            7'h59: begin len = 3'd4; pat = 5'b01101; end  // Y -.--
            7'h5A: begin len = 3'd4; pat = 5'b00011; end  // Z --..
            7'h30: begin len = 3'd5; pat = 5'b11111; end  // 0 -----
            7'h31: begin len = 3'd5; pat = 5'b11110; end  // 1 .----
            7'h32: begin len = 3'd5; pat = 5'b11100; end  // 2 ..---
            7'h33: begin len = 3'd5; pat = 5'b11000; end  // 3 ...--
            7'h34: begin len = 3'd5; pat = 5'b10000; end  // 4 ....-
            7'h35: begin len = 3'd5; pat = 5'b00000; end  // 5 .....
            7'h36: begin len = 3'd5; pat = 5'b00001; end  // 6 -....
            7'h37: begin len = 3'd5; pat = 5'b00011; end  // 7 --...
            7'h38: begin len = 3'd5; pat = 5'b00111; end  // 8 ---..
            7'h39: begin len = 3'd5; pat = 5'b01111; end  // 9 ----.
            default: valid = 1'b0;
        endcase

        code.valid = valid;
        code.len   = len;
        code.pat   = pat;
        code.units = valid ? char_units_calc(len, pat) : 5'd0;
    end

endmodule

// File: rtl/morse_keyer.sv
// -----------------------------------------------------------------------------
// morse_keyer
// Character-serial Morse keyer with unit-exact timing.
//   clk        : system clock, rising edge
//   rst_n      : asynchronous active-low reset
//   chan       : character handshake (slave side: char_in/char_valid in,
//                char_ready out)
//   abort      : synchronous cancel of the character in progress
//   key_out    : registered key line, 1 = tone on
//   busy       : ~char_ready
//   char_units : total units of the last accepted character, latched on accept
//   bad_char   : one-cycle pulse after accepting an unsupported character
// Parameters: UNIT_CYCLES (clocks per unit, >=1), FOLD_CASE (lowercase folding).
// -----------------------------------------------------------------------------
module morse_keyer
    import morse_pkg::*;
#(
    parameter int UNIT_CYCLES = 5_000_000,
    parameter bit FOLD_CASE   = 1'b1
) (
    input  logic          clk,
    input  logic          rst_n,
    morse_keyer_if.slave  chan,
    input  logic          abort,
    output logic          key_out,
    output logic          busy,
    output logic [4:0]    char_units,
    output logic          bad_char
);

    localparam int            TW         = (UNIT_CYCLES > 1) ? $clog2(UNIT_CYCLES) : 1;
    localparam logic [TW-1:0] TIMER_LAST = TW'(UNIT_CYCLES - 1);

    // Unit counter holds "units remaining minus one" for the current state
    localparam logic [1:0] DOT_CNT  = 2'(DOT_UNITS - 1);
    localparam logic [1:0] DASH_CNT = 2'(DASH_UNITS - 1);
    localparam logic [1:0] EGAP_CNT = 2'(EGAP_UNITS - 1);
    localparam logic [1:0] CGAP_CNT = 2'(CGAP_UNITS - 1);
    localparam logic [1:0] WGAP_CNT = 2'(WGAP_UNITS - 1);

    morse_code_t   rom_code;

    state_t        state_reg,  state_next;
    logic [TW-1:0] timer_reg,  timer_next;
    logic [1:0]    cnt_reg,    cnt_next;
    logic [2:0]    elem_reg,   elem_next;
    logic [2:0]    len_reg,    len_next;
    logic [4:0]    pat_reg,    pat_next;
    logic [4:0]    units_reg,  units_next;
    logic          key_reg,    key_next;
    logic          bad_reg,    bad_next;

    logic          tick;
    logic          last_unit;
    logic          ready;
    logic          accept;
    logic [7:0]    pat_ext;
    logic [2:0]    elem_inc;

    morse_rom #(
        .FOLD_CASE (FOLD_CASE)
    ) u_rom (
        .ascii (chan.char_in),
        .code  (rom_code)
    );

    assign tick      = (timer_reg == TIMER_LAST);
    assign last_unit = tick && (cnt_reg == 2'd0);
    assign pat_ext   = {3'b000, pat_reg};
    assign elem_inc  = elem_reg + 3'd1;

    // Ready looks ahead into the final cycle of a character (and the single
    // BAD cycle) so the next character is accepted on the very edge the
    // current one finishes: back-to-back characters have no dead cycles.
    // An abort in those cycles wins, so ready is withheld then.
    assign ready  = (state_reg == IDLE) ||
                    (!abort && ((state_reg == BAD) ||
                                ((state_reg == TAIL) && last_unit)));
    assign accept = chan.char_valid && ready;

    always_comb begin
        state_next = state_reg;
        timer_next = timer_reg;
        cnt_next   = cnt_reg;
        elem_next  = elem_reg;
        len_next   = len_reg;
        pat_next   = pat_reg;
        units_next = units_reg;

        if (accept) begin
            timer_next = '0;
            len_next   = rom_code.len;
            pat_next   = rom_code.pat;
            units_next = rom_code.units;
            elem_next  = 3'd0;
            if (!rom_code.valid) begin
                state_next = BAD;
                cnt_next   = 2'd0;
            end else if (rom_code.len == 3'd0) begin
                state_next = TAIL;
                cnt_next   = WGAP_CNT;
            end else begin
                state_next = MARK;
                cnt_next   = rom_code.pat[0] ? DASH_CNT : DOT_CNT;
            end
        end else if ((state_reg != IDLE) && abort) begin
            state_next = IDLE;
            timer_next = '0;
            cnt_next   = 2'd0;
            elem_next  = 3'd0;
        end else begin
            case (state_reg)
                IDLE: begin
                    timer_next = '0;
                end
                MARK: begin
                    timer_next = tick ? '0 : timer_reg + TW'(1);
                    if (tick) begin
                        if (cnt_reg != 2'd0) begin
                            cnt_next = cnt_reg - 2'd1;
                        end else if (elem_inc == len_reg) begin
                            state_next = TAIL;
                            cnt_next   = CGAP_CNT;
                        end else begin
                            state_next = GAP;
                            cnt_next   = EGAP_CNT;
                        end
                    end
                end
                GAP: begin
                    timer_next = tick ? '0 : timer_reg + TW'(1);
                    if (tick) begin
                        if (cnt_reg != 2'd0) begin
                            cnt_next = cnt_reg - 2'd1;
                        end else begin
                            state_next = MARK;
                            elem_next  = elem_inc;
                            cnt_next   = pat_ext[elem_inc] ? DASH_CNT : DOT_CNT;
                        end
                    end
                end
                TAIL: begin
                    timer_next = tick ? '0 : timer_reg + TW'(1);
                    if (tick) begin
                        if (cnt_reg != 2'd0) begin
                            cnt_next = cnt_reg - 2'd1;
                        end else begin
                            state_next = IDLE;
                        end
                    end
                end
                BAD: begin
                    state_next = IDLE;
                    timer_next = '0;
                end
                default: begin
                    state_next = IDLE;
                    timer_next = '0;
                end
            endcase
        end

        // Outputs are registered from the next state so they change on the
        // same edge as the state itself.
        key_next = (state_next == MARK);
        bad_next = (state_next == BAD);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            timer_reg <= '0;
            cnt_reg   <= 2'd0;
            elem_reg  <= 3'd0;
            len_reg   <= 3'd0;
            pat_reg   <= 5'd0;
            units_reg <= 5'd0;
            key_reg   <= 1'b0;
            bad_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            timer_reg <= timer_next;
            cnt_reg   <= cnt_next;
            elem_reg  <= elem_next;
            len_reg   <= len_next;
            pat_reg   <= pat_next;
            units_reg <= units_next;
            key_reg   <= key_next;
            bad_reg   <= bad_next;
        end
    end

    assign chan.char_ready = ready;
    assign busy            = ~ready;
    assign key_out         = key_reg;
    assign char_units      = units_reg;
    assign bad_char        = bad_reg;

endmodule

// File: doc/morse_keyer.md
# morse_keyer

Character-serial Morse keyer. It accepts one ASCII character per valid/ready handshake, looks up its dot/dash pattern, and drives a single key line with exact unit-based timing: element marks, intra-character gaps, inter-character gaps and word gaps. It also reports the character's total duration in units. It sits between the character source (UART/keyboard buffer) and the tone/LED driver. It replaces the old combinational per-character duration lookup with a timed, parametrised engine.

## Interface
Parameters:
- `UNIT_CYCLES`, default 5_000_000: clock cycles per Morse unit (dot length); legal range ≥ 1.
- `FOLD_CASE`, default 1: 1 maps ASCII 0x61–0x7A to 0x41–0x5A; 0 treats lowercase as unsupported.

Ports:
- `clk`  in  1  single system clock; all logic on rising edge.
- `rst_n`  in  1  reset; asynchronous assert, active-low.
- `char_in`  in  7  ASCII code, sampled on accept.
- `char_valid`  in  1  source has a character.
- `char_ready`  out  1  keyer idle; accept = `char_valid & char_ready` at a rising edge.
- `abort`  in  1  synchronous cancel of the character in progress.
- `key_out`  out  1  1 = tone on; registered.
- `busy`  out  1  equals `~char_ready`.
- `char_units`  out  5  total units of the last accepted character; latched on accept.
- `bad_char`  out  1  one-cycle pulse for an unsupported accepted character.

## Operation
- Supported characters: A–Z, 0–9 (standard ITU patterns), space 0x20, and lowercase if `FOLD_CASE`=1. All others are unsupported.
- Lookup result: `len` (0–5) and `pat[4:0]`. Element i (i=0 sent first) is `pat[i]`: 1=dash, 0=dot.
- Element durations: dot mark 1 unit; dash mark 3 units; gap between elements 1 unit.
- Character trailer: 3 units off after the last element.
- Space: 4 units off with no mark. Together with the previous trailer this gives a 7-unit word gap.
- `char_units` = Σ marks + (len−1) + 3 for letters and digits; 4 for space; 0 for unsupported. Examples: E=4, T=6, A=8, 0=22 (the maximum).
- State machine:
  - IDLE: `char_ready`=1, `key_out`=0.
    - Accept of a supported non-space character → MARK (element 0).
    - Accept of space → TAIL with 4 units.
    - Accept of an unsupported character → BAD.
  - MARK: `key_out`=1 for 1 or 3 units.
    - Not the last element → GAP.
    - Last element → TAIL with 3 units.
  - GAP: `key_out`=0 for 1 unit, then → MARK (next element).
  - TAIL: `key_out`=0 for 3 or 4 units, then → IDLE.
  - BAD: lasts one cycle; `bad_char`=1; → IDLE.
- Unit timer: counts 0..`UNIT_CYCLES`−1 and produces a tick at the terminal count. It is cleared on accept, so every unit is exactly `UNIT_CYCLES` cycles.
- Unit counter: 2 bits, loaded with the state duration on each state entry.
- `abort`, from any state other than IDLE: on the next edge, `key_out`=0, state→IDLE, timer cleared. `char_units` keeps its value. `abort` in IDLE is ignored. If `abort` and `char_valid` are both high in IDLE, the accept proceeds.

## Timing
- Reset values: `key_out`=0, `char_ready`=1, `busy`=0, `char_units`=0, `bad_char`=0; state IDLE; timer 0.
- Reset mid-character drops `key_out` asynchronously.
- Accept at edge t0:
  - `key_out` rises at t0 (MARK first), `char_ready` falls at t0, `char_units` is valid from t0.
  - `char_ready` reasserts at edge t0 + `char_units`·`UNIT_CYCLES`.
  - A new character may be accepted on that same edge, so back-to-back characters have zero dead cycles.
- Unsupported character: `bad_char` is high for the cycle after t0; `char_ready` reasserts at t0+1.
- Each `key_out` transition lands on an edge of the form t0 + n·`UNIT_CYCLES`.
- `char_in` is don't-care while `char_ready`=0.

## Structure
- Package `morse_pkg`:
  - state enum {IDLE, MARK, GAP, TAIL, BAD};
  - constants `DOT_UNITS`=1, `DASH_UNITS`=3, `EGAP_UNITS`=1, `CGAP_UNITS`=3, `WGAP_UNITS`=4;
  - ASCII constants for space, 'A', 'a', '0'.
- Sub-module `morse_rom`: combinational, 7-bit ASCII in → {valid, len[2:0], pat[4:0], units[4:0]}. Case folding is done here.
- `morse_keyer` holds the FSM, unit timer, element index and output registers.

## Test plan
Use `UNIT_CYCLES`=4 unless noted.
- 'E' accepted at t0 → `key_out` high 4 cycles, low 12; `char_units`=4; `char_ready` high again at t0+16.
- 'A' then '0' back-to-back with `char_valid` held → key 4 on/4 off/12 on/12 off, then '0' keyed starting exactly at t0+32; `char_units`=8 then 22.
- Space → `key_out` stays 0, `char_units`=4, ready after 16 cycles. 'a' with `FOLD_CASE`=1 → identical to 'A'; with `FOLD_CASE`=0 → `bad_char` pulse, `char_units`=0.
- '#' (0x23) → `bad_char` high one cycle at t0+1, `key_out` never high, ready at t0+1.
- `abort` during the dash of 'T' → `key_out`=0 and `char_ready`=1 on the next edge; `rst_n` low mid-mark → `key_out`=0 with no clock edge.
- `UNIT_CYCLES`=1, 'S' → key pattern 1 0 1 0 1 0 0 0 over 8 cycles.
